// File: rtl/load_store_unit_if.sv
// Data-memory request/ready bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte-strobed request/ready data bus, load extension and fault reporting.
// Optional MISALIGN_SPLIT_EN: misaligned accesses execute (two beats when crossing a word) instead of faulting.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned TIMEOUT_W      = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic [1:0]  fault_code,
    load_store_unit_if.master mem
);

`ifdef MISALIGN_SPLIT_EN
    localparam int unsigned SHW = 64;
    localparam int unsigned STW = 8;
`else
    localparam int unsigned SHW = 32;
    localparam int unsigned STW = 4;
`endif
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, ACCESS2, RESP} state_t;

    state_t               state;
    logic [2:0]           funct3_q;
    logic [1:0]           off_q;
    logic [TIMEOUT_W-1:0] tmo_cnt;

    logic                 illegal_c;
    logic [1:0]           fault_c;
    logic [31:0]          sized_c;
    logic [3:0]           base_strb_c;
    logic [SHW-1:0]       shifted_c;
    logic [STW-1:0]       strb_c;
    logic [31:0]          wdata_lo_c;
    logic [SHW-1:0]       rword_c;
    logic [31:0]          rsel_c;
    logic [31:0]          load_ext_c;

`ifdef MISALIGN_SPLIT_EN
    logic                 split_q;
    logic [31:0]          wdata_hi_q;
    logic [3:0]           wstrb_hi_q;
    logic [31:0]          rdata_lo_q;
`endif

    assign busy = (state == ACCESS) || (state == ACCESS2) || (state == IDLE && start);

    // Request decode: legality, store lane placement and strobes
    always_comb begin
        illegal_c = is_store ? (funct3 > 3'd2)
                             : (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
        fault_c = 2'b00;
        if (illegal_c) begin
            fault_c = 2'b10;
        end
`ifndef MISALIGN_SPLIT_EN
        else if ((funct3[1:0] == 2'd1 && address[0]) ||
                 (funct3[1:0] == 2'd2 && address[1:0] != 2'b00)) begin
            fault_c = 2'b01;
        end
`endif
        case (funct3[1:0])
            2'd0:    begin sized_c = {24'b0, store_data[7:0]};  base_strb_c = 4'b0001; end
            2'd1:    begin sized_c = {16'b0, store_data[15:0]}; base_strb_c = 4'b0011; end
            default: begin sized_c = store_data;                base_strb_c = 4'b1111; end
        endcase
        shifted_c  = SHW'(sized_c) << {address[1:0], 3'b000};
        strb_c     = STW'(base_strb_c) << address[1:0];
        wdata_lo_c = (funct3[1:0] == 2'd0) ? {4{store_data[7:0]}} : shifted_c[31:0];
    end

    // Load path: merge beats (split case) before shifting and extending
    always_comb begin
`ifdef MISALIGN_SPLIT_EN
        rword_c = (state == ACCESS2) ? {mem.mem_rdata, rdata_lo_q} : {32'b0, mem.mem_rdata};
`else
        rword_c = mem.mem_rdata;
`endif
        rsel_c = 32'(rword_c >> {off_q, 3'b000});
        case (funct3_q)
            3'd0:    load_ext_c = {{24{rsel_c[7]}}, rsel_c[7:0]};
            3'd1:    load_ext_c = {{16{rsel_c[15]}}, rsel_c[15:0]};
            3'd4:    load_ext_c = {24'b0, rsel_c[7:0]};
            3'd5:    load_ext_c = {16'b0, rsel_c[15:0]};
            default: load_ext_c = rsel_c;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            funct3_q       <= '0;
            off_q          <= '0;
            tmo_cnt        <= '0;
            done           <= 1'b0;
            load_data      <= '0;
            fault_code     <= '0;
            mem.mem_req    <= 1'b0;
            mem.mem_we     <= 1'b0;
            mem.mem_addr   <= '0;
            mem.mem_wdata  <= '0;
            mem.mem_wstrb  <= '0;
`ifdef MISALIGN_SPLIT_EN
            split_q        <= 1'b0;
            wdata_hi_q     <= '0;
            wstrb_hi_q     <= '0;
            rdata_lo_q     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        funct3_q <= funct3;
                        off_q    <= address[1:0];
                        tmo_cnt  <= '0;
                        if (fault_c != 2'b00) begin
                            state      <= RESP;
                            done       <= 1'b1;
                            fault_code <= fault_c;
                            load_data  <= '0;
                        end else begin
                            state         <= ACCESS;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= is_store;
                            mem.mem_addr  <= {address[31:2], 2'b00};
                            mem.mem_wdata <= wdata_lo_c;
                            mem.mem_wstrb <= is_store ? strb_c[3:0] : 4'b0000;
`ifdef MISALIGN_SPLIT_EN
                            split_q    <= |strb_c[7:4];
                            wdata_hi_q <= shifted_c[63:32];
                            wstrb_hi_q <= is_store ? strb_c[7:4] : 4'b0000;
`endif
                        end
                    end
                end
                ACCESS, ACCESS2: begin
                    if (mem.mem_ready) begin
                        tmo_cnt <= '0;
`ifdef MISALIGN_SPLIT_EN
                        if (state == ACCESS && split_q) begin
                            state         <= ACCESS2;
                            mem.mem_addr  <= mem.mem_addr + 32'd4;
                            mem.mem_wdata <= wdata_hi_q;
                            mem.mem_wstrb <= wstrb_hi_q;
                            rdata_lo_q    <= mem.mem_rdata;
                        end else
`endif
                        begin
                            state         <= RESP;
                            done          <= 1'b1;
                            fault_code    <= 2'b00;
                            load_data     <= mem.mem_we ? 32'b0 : load_ext_c;
                            mem.mem_req   <= 1'b0;
                            mem.mem_we    <= 1'b0;
                            mem.mem_wstrb <= 4'b0000;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Bus never answered: abandon the beat and report a timeout
                        state         <= RESP;
                        done          <= 1'b1;
                        fault_code    <= 2'b11;
                        load_data     <= '0;
                        mem.mem_req   <= 1'b0;
                        mem.mem_we    <= 1'b0;
                        mem.mem_wstrb <= 4'b0000;
                    end else begin
                        tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written corner sequences and
// randomized accesses checked against a byte-level reference model.
module tb_load_store_unit;
    localparam int TMO = 256;
`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic [1:0]  fault_code;

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT_CYCLES(TMO), .TIMEOUT_W(9)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .address    (address),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .fault_code (fault_code),
        .mem        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       fault;
        int               nbeats;
        logic [1:0][31:0] baddr;
        logic [1:0][3:0]  strb;
        logic [1:0][31:0] wdata;
        logic [31:0]      load;
        int               done_cyc;
        int               req_cyc;
    } exp_t;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rd0;
        logic [31:0] rd1;
        int          lat;
        logic [1:0]  fault;
        logic [31:0] load;
        int          done_cyc;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    logic        obs_busy0;
    logic [1:0]  obs_fault;
    logic [31:0] obs_load;
    int          obs_done_cyc;
    int          obs_nbeats;
    int          obs_req_cyc;
    int          obs_busy_err;
    logic        obs_resp_idle;
    logic        obs_after_idle;
    logic [31:0] obs_addr  [4];
    logic        obs_we    [4];
    logic [3:0]  obs_strb  [4];
    logic [31:0] obs_wdata [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    // Reference: the access as a list of bytes at addr..addr+n-1, mapped onto word beats
    function automatic exp_t model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] sd, input logic [31:0] rd0,
                                   input logic [31:0] rd1, input int lat);
        exp_t        e;
        int          n;
        int          b;
        int          beat;
        int          lane;
        bit          illegal;
        logic [31:0] val;
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        illegal = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        e.fault = 2'd0; e.nbeats = 0; e.baddr = '0; e.strb = '0; e.wdata = '0;
        e.load = '0; e.done_cyc = 1; e.req_cyc = 0;
        if (illegal) begin e.fault = 2'd2; return e; end
        if ((int'(addr[1:0]) % n) != 0 && !SPLIT) begin e.fault = 2'd1; return e; end
        if (lat >= TMO) begin e.fault = 2'd3; e.req_cyc = TMO; e.done_cyc = TMO + 1; return e; end
        e.nbeats = (int'(addr[1:0]) + n > 4) ? 2 : 1;
        e.baddr[0] = {addr[31:2], 2'b00};
        e.baddr[1] = e.baddr[0] + 32'd4;
        val = '0;
        for (int i = 0; i < n; i++) begin
            b = int'(addr[1:0]) + i;
            beat = b / 4;
            lane = b % 4;
            e.strb[beat][lane] = 1'b1;
            e.wdata[beat][lane*8 +: 8] = sd[i*8 +: 8];
            val[i*8 +: 8] = (beat == 0) ? rd0[lane*8 +: 8] : rd1[lane*8 +: 8];
        end
        if (!st) begin
            if (!f3[2] && n == 1 && val[7])  val[31:8]  = '1;
            if (!f3[2] && n == 2 && val[15]) val[31:16] = '1;
            e.load = val;
        end
        e.done_cyc = 1 + e.nbeats * (lat + 1);
        e.req_cyc  = e.nbeats * (lat + 1);
        return e;
    endfunction

    // Issue one access from a negedge; act as the memory slave with 'lat' wait cycles per beat
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [31:0] rd0, input logic [31:0] rd1,
                          input int lat, input int budget);
        int wait_n;
        int k;
        bit got_done;
        obs_fault = 'x; obs_load = 'x; obs_done_cyc = -1; obs_nbeats = 0;
        obs_req_cyc = 0; obs_busy_err = 0; obs_resp_idle = 1'b0; obs_after_idle = 1'b0;
        is_store = st; funct3 = f3; address = addr; store_data = sd; start = 1'b1;
        #1 obs_busy0 = busy;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        address = $urandom; store_data = $urandom; funct3 = 3'($urandom_range(0, 7));
        wait_n = 0; k = 1; got_done = 0;
        while (!got_done && k <= budget) begin
            if (done) begin
                got_done = 1;
                obs_done_cyc = k;
                obs_fault = fault_code;
                obs_load = load_data;
                obs_resp_idle = !bus.mem_req && !bus.mem_we && bus.mem_wstrb == 4'b0 && !busy;
                bus.mem_ready = 1'b0;
            end else begin
                if (!busy) obs_busy_err++;
                if (bus.mem_req) begin
                    obs_req_cyc++;
                    if (wait_n == lat) begin
                        if (obs_nbeats < 4) begin
                            obs_addr[obs_nbeats]  = bus.mem_addr;
                            obs_we[obs_nbeats]    = bus.mem_we;
                            obs_strb[obs_nbeats]  = bus.mem_wstrb;
                            obs_wdata[obs_nbeats] = bus.mem_wdata;
                        end
                        bus.mem_ready = 1'b1;
                        bus.mem_rdata = (obs_nbeats == 0) ? rd0 : rd1;
                        obs_nbeats++;
                        wait_n = 0;
                    end else begin
                        bus.mem_ready = 1'b0;
                        bus.mem_rdata = $urandom;
                        wait_n++;
                    end
                end else begin
                    bus.mem_ready = 1'b0;
                end
                @(posedge clk);
                @(negedge clk);
                k++;
            end
        end
        bus.mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        obs_after_idle = !done && !busy && !bus.mem_req;
    endtask

    task automatic check_op(input string tag, input logic st, input exp_t e);
        logic [31:0] m;
        chk({tag, ".busy_at_start"}, 32'(obs_busy0), 32'd1);
        chk({tag, ".fault"}, 32'(obs_fault), 32'(e.fault));
        chk({tag, ".done_cycle"}, 32'(obs_done_cyc), 32'(e.done_cyc));
        chk({tag, ".load_data"}, obs_load, e.load);
        chk({tag, ".beats"}, 32'(obs_nbeats), 32'(e.nbeats));
        chk({tag, ".req_cycles"}, 32'(obs_req_cyc), 32'(e.req_cyc));
        chk({tag, ".busy_gaps"}, 32'(obs_busy_err), 32'd0);
        chk({tag, ".resp_bus_idle"}, 32'(obs_resp_idle), 32'd1);
        chk({tag, ".back_to_idle"}, 32'(obs_after_idle), 32'd1);
        for (int i = 0; i < e.nbeats && i < obs_nbeats; i++) begin
            chk($sformatf("%s.beat%0d_addr", tag, i), obs_addr[i], e.baddr[i]);
            chk($sformatf("%s.beat%0d_we", tag, i), 32'(obs_we[i]), 32'(st));
            chk($sformatf("%s.beat%0d_wstrb", tag, i), 32'(obs_strb[i]), st ? 32'(e.strb[i]) : 32'd0);
            if (st) begin
                for (int j = 0; j < 4; j++) m[j*8 +: 8] = {8{e.strb[i][j]}};
                chk($sformatf("%s.beat%0d_wdata", tag, i), obs_wdata[i] & m, e.wdata[i] & m);
            end
        end
    endtask

    vec_t        vecs [12];
    logic [2:0]  load_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    exp_t        e;
    logic        r_st;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    int          r_lat;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 3'd2, 32'h100, 32'h0,    32'hDEADBEEF, 32'h0, 0, 2'd0, 32'hDEADBEEF, 2};
        vecs[1]  = '{1'b0, 3'd0, 32'h103, 32'h0,    32'h80112233, 32'h0, 0, 2'd0, 32'hFFFFFF80, 2};
        vecs[2]  = '{1'b0, 3'd4, 32'h103, 32'h0,    32'h80112233, 32'h0, 0, 2'd0, 32'h00000080, 2};
        vecs[3]  = '{1'b0, 3'd1, 32'h102, 32'h0,    32'h80112233, 32'h0, 0, 2'd0, 32'hFFFF8011, 2};
        vecs[4]  = '{1'b0, 3'd5, 32'h102, 32'h0,    32'h80112233, 32'h0, 0, 2'd0, 32'h00008011, 2};
        vecs[5]  = '{1'b1, 3'd1, 32'h202, 32'hABCD, 32'h0,        32'h0, 0, 2'd0, 32'h0,        2};
        vecs[6]  = '{1'b0, 3'd3, 32'h100, 32'h0,    32'h12345678, 32'h0, 0, 2'd2, 32'h0,        1};
        vecs[7]  = '{1'b1, 3'd4, 32'h100, 32'h55,   32'h0,        32'h0, 0, 2'd2, 32'h0,        1};
        vecs[9]  = '{1'b0, 3'd2, 32'h10C, 32'h0,    32'h12345678, 32'h0, 3, 2'd0, 32'h12345678, 5};
        vecs[10] = '{1'b1, 3'd0, 32'h301, 32'h5A,   32'h0,        32'h0, 1, 2'd0, 32'h0,        3};
`ifdef MISALIGN_SPLIT_EN
        vecs[8]  = '{1'b0, 3'd2, 32'h101, 32'h0, 32'h44332211, 32'h88776655, 0, 2'd0, 32'h55443322, 3};
        vecs[11] = '{1'b0, 3'd1, 32'h105, 32'h0, 32'h00ABCD00, 32'h0,        0, 2'd0, 32'hFFFFABCD, 2};
`else
        vecs[8]  = '{1'b0, 3'd2, 32'h101, 32'h0, 32'h44332211, 32'h88776655, 0, 2'd1, 32'h0, 1};
        vecs[11] = '{1'b0, 3'd1, 32'h105, 32'h0, 32'h00ABCD00, 32'h0,        0, 2'd1, 32'h0, 1};
`endif

        rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = '0; address = '0; store_data = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.mem_req", 32'(bus.mem_req), 32'd0);
        chk("reset.mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        chk("reset.load_data", load_data, 32'd0);
        chk("reset.fault_code", 32'(fault_code), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].sd, vecs[i].rd0, vecs[i].rd1,
                   vecs[i].lat, 50);
            chk($sformatf("vec%0d.fault", i), 32'(obs_fault), 32'(vecs[i].fault));
            chk($sformatf("vec%0d.load_data", i), obs_load, vecs[i].load);
            chk($sformatf("vec%0d.done_cycle", i), 32'(obs_done_cyc), 32'(vecs[i].done_cyc));
            e = model(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].sd, vecs[i].rd0, vecs[i].rd1,
                      vecs[i].lat);
            check_op($sformatf("vec%0d", i), vecs[i].st, e);
        end

        // SH to the upper half of a word
        run_op(1'b1, 3'd1, 32'h202, 32'h0000ABCD, 32'h0, 32'h0, 0, 50);
        chk("sh.mem_we", 32'(obs_we[0]), 32'd1);
        chk("sh.wstrb", 32'(obs_strb[0]), 32'b1100);
        chk("sh.wdata_hi", 32'(obs_wdata[0][31:16]), 32'hABCD);
        chk("sh.addr", obs_addr[0], 32'h200);

        // Bus never ready: timeout after TMO cycles of mem_req
        run_op(1'b0, 3'd2, 32'h500, 32'h0, 32'h0, 32'h0, 100000, TMO + 20);
        chk("timeout.fault", 32'(obs_fault), 32'd3);
        chk("timeout.req_cycles", 32'(obs_req_cyc), 32'(TMO));
        e = model(1'b0, 3'd2, 32'h500, 32'h0, 32'h0, 32'h0, 100000);
        check_op("timeout", 1'b0, e);

        // Reset in the middle of an access, then an immediate new access
        is_store = 1'b0; funct3 = 3'd2; address = 32'h400; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("midrst.req_before", 32'(bus.mem_req), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst.mem_req", 32'(bus.mem_req), 32'd0);
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        rst_n = 1'b1;
        run_op(1'b0, 3'd2, 32'h404, 32'h0, 32'hCAFEF00D, 32'h0, 0, 50);
        e = model(1'b0, 3'd2, 32'h404, 32'h0, 32'hCAFEF00D, 32'h0, 0);
        check_op("post_rst", 1'b0, e);

        for (int i = 0; i < 60; i++) begin
            r_st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) r_f3 = 3'($urandom_range(0, 7));
            else if (r_st)                 r_f3 = 3'($urandom_range(0, 2));
            else                           r_f3 = load_f3[$urandom_range(0, 4)];
            r_addr = 32'($urandom_range(0, 32'hFFFF)) + 32'h1000;
            r_lat = $urandom_range(0, 3);
            begin
                logic [31:0] sd_r, rd0_r, rd1_r;
                sd_r = $urandom; rd0_r = $urandom; rd1_r = $urandom;
                run_op(r_st, r_f3, r_addr, sd_r, rd0_r, rd1_r, r_lat, 50);
                e = model(r_st, r_f3, r_addr, sd_r, rd0_r, rd1_r, r_lat);
                check_op($sformatf("rnd%0d", i), r_st, e);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
